dw_conv_line_buf: RTL and testbench

Line buffer that sits directly upstream of the depthwise-conv window generator. It accepts a row-major pixel stream, one pixel per beat carrying all channels. For every pixel from image row 2 onward it emits the 3-tall vertical column for each channel: current row, row−1 and row−2. The window generator shifts these columns horizontally to build the 3×3 windows.

---
 rtl/dw_conv_pkg.sv | 24 ++
 rtl/dw_line_mem.sv | 22 ++
 rtl/dw_conv_line_buf.sv | 112 +++++++++++
 tb/tb_dw_conv_line_buf.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dw_conv_pkg.sv
// Shared types and helpers for the depthwise-conv front end (line buffer and window generator).
// Widths below describe the default 18ch x 8b x 56x56 configuration.
package dw_conv_pkg;

  localparam int DEF_CHANNEL_NUM = 18;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_IMG_WIDTH   = 56;
  localparam int DEF_IMG_HEIGHT  = 56;

  localparam int COL_W = $clog2(DEF_IMG_WIDTH);
  localparam int ROW_W = $clog2(DEF_IMG_HEIGHT);
  localparam int PIX_W = DEF_CHANNEL_NUM * DEF_DATA_WIDTH;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } lb_state_e;

  // Bit offset of channel c, tap k inside a packed 3-tall column.
  function automatic int col_idx(input int c, input int k, input int dw);
    return (c * 3 + k) * dw;
  endfunction

endpackage

// File: rtl/dw_line_mem.sv
// One image line of pixels: single write port, combinational read at the same address.
// Kept small and read asynchronously so it lands in distributed RAM.
module dw_line_mem #(
  parameter int DEPTH = 56,
  parameter int WIDTH = 144
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dw_conv_line_buf.sv
// Line buffer feeding the depthwise-conv window generator: emits, per pixel from row 2 on,
// the vertical column {row-2, row-1, row} for every channel, one cycle after the pixel.
module dw_conv_line_buf
  import dw_conv_pkg::*;
#(
  parameter int CHANNEL_NUM = 18,
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 56,
  parameter int IMG_HEIGHT  = 56
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                clr,
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0]   data_in,
  input  logic                                valid_in,
  output logic [CHANNEL_NUM*3*DATA_WIDTH-1:0] data_out,
  output logic                                valid_out,
  output logic                                row_end,
  output logic                                frame_done
);

  localparam int PW = CHANNEL_NUM * DATA_WIDTH;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  lb_state_e         state, state_nxt;
  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic              accept, emit, last_col, last_row;
  logic [PW-1:0]     line1_rd, line2_rd;
  logic [3*PW-1:0]   col_pack;

  assign accept   = valid_in & ~clr;
  assign last_col = (col_cnt == CW'(IMG_WIDTH - 1));
  assign last_row = (row_cnt == RW'(IMG_HEIGHT - 1));

  // LINE2 takes LINE1's old content at the same column while LINE1 takes the new pixel.
  dw_line_mem #(.DEPTH(IMG_WIDTH), .WIDTH(PW)) u_line1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_cnt),
    .wdata (data_in),
    .rdata (line1_rd)
  );

  dw_line_mem #(.DEPTH(IMG_WIDTH), .WIDTH(PW)) u_line2 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_cnt),
    .wdata (line1_rd),
    .rdata (line2_rd)
  );

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_pack
    assign col_pack[col_idx(c, 0, DATA_WIDTH) +: DATA_WIDTH] = data_in[c*DATA_WIDTH +: DATA_WIDTH];
    assign col_pack[col_idx(c, 1, DATA_WIDTH) +: DATA_WIDTH] = line1_rd[c*DATA_WIDTH +: DATA_WIDTH];
    assign col_pack[col_idx(c, 2, DATA_WIDTH) +: DATA_WIDTH] = line2_rd[c*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    case (state)
      FILL: begin
        if (accept && last_col && row_cnt == RW'(1)) state_nxt = STREAM;
      end
      STREAM: begin
        emit = accept;
        if (accept && last_col && last_row) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
    if (clr) state_nxt = FILL;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= FILL;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (accept) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
    end
  end

  // Output stage: one cycle after the accepted pixel; data_out only moves on emitted beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      row_end    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= emit;
      row_end    <= emit & last_col;
      frame_done <= emit & last_col & last_row;
      if (emit) data_out <= col_pack;
    end
  end

endmodule

// File: tb/tb_dw_conv_line_buf.sv
// Directed bench for dw_conv_line_buf at 2ch x 8b x 4x4; pixel (r,c) ch = r*16+c*4+ch+offset.
module tb_dw_conv_line_buf;

  localparam int CH = 2;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic              clk;
  logic              rstn;
  logic              clr;
  logic [CH*DW-1:0]  data_in;
  logic              valid_in;
  logic [CH*3*DW-1:0] data_out;
  logic              valid_out;
  logic              row_end;
  logic              frame_done;

  int checks;
  int failures;
  int nv;
  int nre;
  logic [CH*3*DW-1:0] hold;

  dw_conv_line_buf #(
    .CHANNEL_NUM (CH),
    .DATA_WIDTH  (DW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .row_end    (row_end),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [CH*DW-1:0] pix(input int r, input int c, input int off);
    logic [CH*DW-1:0] p;
    p = '0;
    for (int ch = 0; ch < CH; ch++) p[ch*DW +: DW] = 8'(r*16 + c*4 + ch + off);
    return p;
  endfunction

  function automatic logic [CH*3*DW-1:0] exp_col(input int r, input int c, input int off);
    logic [CH*3*DW-1:0] e;
    e = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int k = 0; k < 3; k++)
        e[(ch*3+k)*DW +: DW] = 8'((r-k)*16 + c*4 + ch + off);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input int r, input int c, input int off);
    valid_in = 1'b1;
    data_in  = pix(r, c, off);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    if (r >= 2) hold = exp_col(r, c, off);
    chk("valid_out", 64'(valid_out), 64'(r >= 2));
    chk("data_out", 64'(data_out), 64'(hold));
    chk("row_end", 64'(row_end), 64'(r >= 2 && c == W-1));
    chk("frame_done", 64'(frame_done), 64'(r == H-1 && c == W-1));
    nv  += int'(valid_out);
    nre += int'(row_end);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("gap_valid_out", 64'(valid_out), 64'd0);
      chk("gap_row_end", 64'(row_end), 64'd0);
      chk("gap_frame_done", 64'(frame_done), 64'd0);
      chk("gap_data_hold", 64'(data_out), 64'(hold));
    end
  endtask

  task automatic frame(input int off, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
        send(r, c, off);
      end
  endtask

  initial begin
    clk = 1'b0; rstn = 1'b0; clr = 1'b0; valid_in = 1'b0; data_in = '0;
    checks = 0; failures = 0; nv = 0; nre = 0; hold = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_row_end", 64'(row_end), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    rstn = 1'b1;

    idle(100);

    nv = 0; nre = 0;
    frame(0, 1'b0);
    chk("cont_valid_beats", 64'(nv), 64'd8);
    chk("cont_row_ends", 64'(nre), 64'd2);
    idle(2);

    nv = 0; nre = 0;
    frame(0, 1'b1);
    chk("gap_valid_beats", 64'(nv), 64'd8);
    chk("gap_row_ends", 64'(nre), 64'd2);
    idle(2);

    nv = 0; nre = 0;
    frame(0, 1'b0);
    frame(8'h40, 1'b0);
    chk("b2b_valid_beats", 64'(nv), 64'd16);
    chk("b2b_row_ends", 64'(nre), 64'd4);
    idle(1);

    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) send(r, c, 8'h80);
    send(2, 0, 8'h80);
    valid_in = 1'b1; clr = 1'b1; data_in = pix(2, 1, 8'h80);
    @(posedge clk);
    #1;
    valid_in = 1'b0; clr = 1'b0;
    chk("clr_valid_out", 64'(valid_out), 64'd0);
    chk("clr_row_end", 64'(row_end), 64'd0);
    chk("clr_frame_done", 64'(frame_done), 64'd0);
    chk("clr_data_hold", 64'(data_out), 64'(hold));
    nv = 0; nre = 0;
    frame(8'h80, 1'b0);
    chk("clr_valid_beats", 64'(nv), 64'd8);
    idle(1);

    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++) send(r, c, 8'h20);
    send(2, 0, 8'h20);
    send(2, 1, 8'h20);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid_out", 64'(valid_out), 64'd0);
    chk("arst_row_end", 64'(row_end), 64'd0);
    chk("arst_frame_done", 64'(frame_done), 64'd0);
    chk("arst_data_out", 64'(data_out), 64'd0);
    hold = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    nv = 0; nre = 0;
    frame(0, 1'b0);
    chk("arst_valid_beats", 64'(nv), 64'd8);
    chk("arst_row_ends", 64'(nre), 64'd2);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
